// File: rtl/mult_share_arbiter_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
// rr_pick finds the next round-robin grant for up to MAX_REQ requesters.
package mult_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int OP_W    = 8;
    localparam int RES_W   = 16;
    localparam int MAX_REQ = 8;

    // First set bit strictly after 'last', wrapping modulo n; returns 'last' when nothing is valid.
    function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                           input logic [2:0]         last,
                                           input int unsigned        n);
        logic [2:0]  pick;
        logic        found;
        int unsigned idx;
        pick  = last;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if ((k <= n) && !found) begin
                idx = (32'(last) + k) % n;
                if (valid[idx[2:0]]) begin
                    pick  = idx[2:0];
                    found = 1'b1;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus binary index.
// The last-grant pointer is owned by the instantiating block.
module rr_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_valid,
    input  logic [ID_W-1:0]    i_last_gnt,
    input  logic               i_enable,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [ID_W-1:0]    o_gnt_idx
);

    logic [MAX_REQ-1:0] w_valid_ext;
    logic [2:0]         w_last_ext;
    logic [2:0]         w_pick;

    always_comb begin
        w_valid_ext                = '0;
        w_valid_ext[NUM_REQ-1:0]   = i_valid;
    end

    assign w_last_ext = 3'(i_last_gnt);
    assign w_pick     = rr_pick(w_valid_ext, w_last_ext, NUM_REQ);
    assign o_gnt_idx  = ID_W'(w_pick);

    // Grant only exists while enabled and someone is actually asking.
    assign o_gnt = (i_enable && (|i_valid)) ? (NUM_REQ'(1) << o_gnt_idx) : '0;

endmodule

// File: rtl/mult_share_arbiter.sv
// Shares one 8x8 unsigned multiplier among NUM_REQ requesters, one op in flight.
// Optional perf counters (op_count, stall_count) when MULT_SHARE_PERF_EN is defined.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are both
// high; the source holds valid and payload stable until then, and may drop valid
// beforehand to withdraw. req_ready is combinational in IDLE only; rsp_valid is
// registered and held with rsp_id/rsp_data until rsp_ready.
module mult_share_arbiter
    import mult_share_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [NUM_REQ*OP_W-1:0] req_a,
    input  logic [NUM_REQ*OP_W-1:0] req_b,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [ID_W-1:0]         rsp_id,
    output logic [RES_W-1:0]        rsp_data,
    output logic                    busy,
    output state_t                  dbg_state
`ifdef MULT_SHARE_PERF_EN
    ,
    output logic [15:0]             op_count,
    output logic [15:0]             stall_count
`endif
);

    state_t            r_state;
    logic [ID_W-1:0]   r_last_gnt;
    logic [OP_W-1:0]   r_a_q;
    logic [OP_W-1:0]   r_b_q;
    logic [ID_W-1:0]   r_id_q;
    logic              r_rsp_valid;
    logic [ID_W-1:0]   r_rsp_id;
    logic [RES_W-1:0]  r_rsp_data;

    logic [NUM_REQ-1:0] w_gnt;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [OP_W-1:0]    w_sel_a;
    logic [OP_W-1:0]    w_sel_b;
    logic [RES_W-1:0]   w_product;
    logic               w_rsp_hs;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_arbiter (
        .i_valid    (req_valid),
        .i_last_gnt (r_last_gnt),
        .i_enable   (r_state == IDLE),
        .o_gnt      (w_gnt),
        .o_gnt_idx  (w_gnt_idx)
    );

    assign w_sel_a   = req_a[w_gnt_idx*OP_W +: OP_W];
    assign w_sel_b   = req_b[w_gnt_idx*OP_W +: OP_W];
    assign w_product = RES_W'(r_a_q) * RES_W'(r_b_q);
    assign w_rsp_hs  = r_rsp_valid && rsp_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_last_gnt  <= ID_W'(NUM_REQ - 1);
            r_a_q       <= '0;
            r_b_q       <= '0;
            r_id_q      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_data  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|w_gnt) begin
                        r_a_q      <= w_sel_a;
                        r_b_q      <= w_sel_b;
                        r_id_q     <= w_gnt_idx;
                        r_last_gnt <= w_gnt_idx;
                        r_state    <= MUL;
                    end
                end
                MUL: begin
                    r_rsp_data  <= w_product;
                    r_rsp_id    <= r_id_q;
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign req_ready = w_gnt;
    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_data  = r_rsp_data;
    assign busy      = (r_state != IDLE);
    assign dbg_state = r_state;

`ifdef MULT_SHARE_PERF_EN
    logic [15:0] r_op_count;
    logic [15:0] r_stall_count;

    // op_count wraps naturally; stall_count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op_count    <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_rsp_hs) begin
                r_op_count <= r_op_count + 16'd1;
            end
            if (r_rsp_valid && !rsp_ready && (r_stall_count != 16'hFFFF)) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign op_count    = r_op_count;
    assign stall_count = r_stall_count;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed scenarios plus a randomized
// run scored against a transaction-level round-robin model.
module tb_mult_share_arbiter;
    import mult_share_pkg::*;

    localparam int N    = 4;
    localparam int ID_W = 2;
    localparam int W    = ID_W + 16;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*8-1:0]  req_a;
    logic [N*8-1:0]  req_b;
    logic [N-1:0]    req_ready;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [ID_W-1:0] rsp_id;
    logic [15:0]     rsp_data;
    logic            busy;
    state_t          dbg_state;
`ifdef MULT_SHARE_PERF_EN
    logic [15:0]     op_count;
    logic [15:0]     stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   op_a [N];
    logic [7:0]   op_b [N];
    logic [W-1:0] exp_q[$];

    mult_share_arbiter #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .busy        (busy),
        .dbg_state   (dbg_state)
`ifdef MULT_SHARE_PERF_EN
        ,
        .op_count    (op_count),
        .stall_count (stall_count)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- driver ----------------
    task automatic drive_req(input int i, input logic [7:0] a, input logic [7:0] b);
        op_a[i]          = a;
        op_b[i]          = b;
        req_a[i*8 +: 8]  = a;
        req_b[i*8 +: 8]  = b;
        req_valid[i]     = 1'b1;
    endtask

    // Round-robin rule: first valid requester after 'last', wrapping; -1 if none.
    function automatic int model_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        apply_reset();
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        n_checks++; if (rsp_data !== 16'd0) begin n_errors++; $display("FAIL reset_rsp_data: got %0d want 0", rsp_data); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (dbg_state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_single();
        apply_reset();
        drive_req(0, 8'd12, 8'd10);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL single_ready: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL single_ready_mul: got %b want 0000", req_ready); end
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_early_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL single_busy: got %b want 1", busy); end
        tick();
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL single_rsp_valid: got %b want 1", rsp_valid); end
        n_checks++; if (rsp_id !== 2'd0) begin n_errors++; $display("FAIL single_rsp_id: got %0d want 0", rsp_id); end
        n_checks++; if (rsp_data !== 16'd120) begin n_errors++; $display("FAIL single_rsp_data: got %0d want 120", rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL single_done_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL single_done_busy: got %b want 0", busy); end
    endtask

    task automatic test_round_robin();
        int exp_id;
        apply_reset();
        for (int i = 0; i < N; i++) drive_req(i, 8'(i + 1), 8'd3);
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            exp_id = g % N;
            n_checks++; if (req_ready !== 4'(1 << exp_id)) begin n_errors++; $display("FAIL rr_grant[%0d]: got %b want %b", g, req_ready, 4'(1 << exp_id)); end
            tick();
            n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL rr_ready_mul[%0d]: got %b want 0000", g, req_ready); end
            tick();
            n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL rr_rsp_valid[%0d]: got %b want 1", g, rsp_valid); end
            n_checks++; if (rsp_id !== 2'(exp_id)) begin n_errors++; $display("FAIL rr_rsp_id[%0d]: got %0d want %0d", g, rsp_id, exp_id); end
            n_checks++; if (rsp_data !== 16'((exp_id + 1) * 3)) begin n_errors++; $display("FAIL rr_rsp_data[%0d]: got %0d want %0d", g, rsp_data, (exp_id + 1) * 3); end
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        apply_reset();
        drive_req(1, 8'd200, 8'd100);
        #1;
        n_checks++; if (req_ready !== 4'b0010) begin n_errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        drive_req(3, 8'd7, 8'd7);
        tick();
        for (int c = 0; c < 5; c++) begin
            n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL bp_valid[%0d]: got %b want 1", c, rsp_valid); end
            n_checks++; if (rsp_id !== 2'd1) begin n_errors++; $display("FAIL bp_id[%0d]: got %0d want 1", c, rsp_id); end
            n_checks++; if (rsp_data !== 16'd20000) begin n_errors++; $display("FAIL bp_data[%0d]: got %0d want 20000", c, rsp_data); end
            n_checks++; if (req_ready !== 4'b0000) begin n_errors++; $display("FAIL bp_ready[%0d]: got %b want 0000", c, req_ready); end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b1) begin n_errors++; $display("FAIL bp_release_valid: got %b want 1", rsp_valid); end
        tick();
        rsp_ready = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL bp_done_valid: got %b want 0", rsp_valid); end
        n_checks++; if (req_ready !== 4'b1000) begin n_errors++; $display("FAIL bp_waiter_grant: got %b want 1000", req_ready); end
        req_valid = '0;
    endtask

    task automatic test_extremes();
        logic [7:0]  ta [4];
        logic [7:0]  tb [4];
        logic [15:0] tp [4];
        ta[0] = 8'd255; tb[0] = 8'd255; tp[0] = 16'hFE01;
        ta[1] = 8'd0;   tb[1] = 8'd200; tp[1] = 16'd0;
        ta[2] = 8'd255; tb[2] = 8'd1;   tp[2] = 16'd255;
        ta[3] = 8'd128; tb[3] = 8'd2;   tp[3] = 16'd256;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            drive_req(2, ta[k], tb[k]);
            tick();
            req_valid = '0;
            tick();
            n_checks++; if (rsp_data !== tp[k]) begin n_errors++; $display("FAIL extreme_data[%0d]: got %h want %h", k, rsp_data, tp[k]); end
            n_checks++; if (rsp_id !== 2'd2) begin n_errors++; $display("FAIL extreme_id[%0d]: got %0d want 2", k, rsp_id); end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid_op();
        apply_reset();
        drive_req(0, 8'd9, 8'd9);
        tick();
        req_valid = '0;
        #1;
        n_checks++; if (busy !== 1'b1) begin n_errors++; $display("FAIL midrst_busy_before: got %b want 1", busy); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_valid: got %b want 0", rsp_valid); end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
        tick();
        n_checks++; if (rsp_valid !== 1'b0) begin n_errors++; $display("FAIL midrst_no_rsp: got %b want 0", rsp_valid); end
        drive_req(0, 8'd5, 8'd6);
        drive_req(2, 8'd7, 8'd8);
        #1;
        n_checks++; if (req_ready !== 4'b0001) begin n_errors++; $display("FAIL midrst_ptr: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        n_checks++; if (rsp_data !== 16'd30) begin n_errors++; $display("FAIL midrst_data: got %0d want 30", rsp_data); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
    endtask

    task automatic test_random();
        int          last_m;
        bit          outst;
        int          age;
        int          w;
        int          clr;
        logic [3:0]  exp_rdy;
        logic        exp_rv;
        apply_reset();
        last_m = N - 1;
        outst  = 1'b0;
        age    = 0;
        clr    = -1;
        exp_q.delete();
        for (int cyc = 0; cyc < 900; cyc++) begin
            if (clr >= 0) req_valid[clr] = 1'b0;
            clr = -1;
            if (cyc < 780) begin
                for (int i = 0; i < N; i++) begin
                    if (!req_valid[i]) begin
                        if ($urandom_range(0, 3) == 0) drive_req(i, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    end else if ($urandom_range(0, 31) == 0) begin
                        req_valid[i] = 1'b0;
                    end
                end
                rsp_ready = ($urandom_range(0, 2) != 0);
            end else begin
                req_valid = '0;
                rsp_ready = 1'b1;
            end
            #1;
            w       = outst ? -1 : model_pick(req_valid, last_m);
            exp_rdy = (w >= 0) ? 4'(1 << w) : 4'b0000;
            exp_rv  = outst && (age >= 2);
            n_checks++; if (req_ready !== exp_rdy) begin n_errors++; $display("FAIL rand_ready@%0d: got %b want %b", cyc, req_ready, exp_rdy); end
            n_checks++; if (rsp_valid !== exp_rv) begin n_errors++; $display("FAIL rand_rsp_valid@%0d: got %b want %b", cyc, rsp_valid, exp_rv); end
            if (exp_rv && exp_q.size() > 0) begin
                n_checks++; if ({rsp_id, rsp_data} !== exp_q[0]) begin n_errors++; $display("FAIL rand_rsp@%0d: got id=%0d data=%0d want id=%0d data=%0d", cyc, rsp_id, rsp_data, exp_q[0][W-1:16], exp_q[0][15:0]); end
            end
            if (w >= 0) begin
                exp_q.push_back({ID_W'(w), 16'(op_a[w]) * 16'(op_b[w])});
                last_m = w;
                outst  = 1'b1;
                age    = 0;
                clr    = w;
            end else if (exp_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                outst = 1'b0;
            end
            tick();
            age++;
        end
        n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL rand_drain: got %0d pending want 0", exp_q.size()); end
        rsp_ready = 1'b0;
    endtask

`ifdef MULT_SHARE_PERF_EN
    task automatic test_perf();
        int stall [3];
        stall[0] = 0; stall[1] = 4; stall[2] = 0;
        apply_reset();
        #1;
        n_checks++; if (op_count !== 16'd0) begin n_errors++; $display("FAIL perf_op_reset: got %0d want 0", op_count); end
        n_checks++; if (stall_count !== 16'd0) begin n_errors++; $display("FAIL perf_stall_reset: got %0d want 0", stall_count); end
        for (int k = 0; k < 3; k++) begin
            drive_req(1, 8'(k + 2), 8'd5);
            tick();
            req_valid = '0;
            tick();
            repeat (stall[k]) tick();
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
        end
        #1;
        n_checks++; if (op_count !== 16'd3) begin n_errors++; $display("FAIL perf_op_count: got %0d want 3", op_count); end
        n_checks++; if (stall_count !== 16'd4) begin n_errors++; $display("FAIL perf_stall_count: got %0d want 4", stall_count); end
    endtask
`endif

    // ---------------- sequence / report ----------------
    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        for (int i = 0; i < N; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_reset_mid_op();
        test_random();
`ifdef MULT_SHARE_PERF_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
